// File: rtl/systolic_seq.sv
// Job sequencer for an N x N output-stationary systolic MAC array: clears the
// accumulators, schedules the skewed operand injection, flushes and drains results.
module systolic_seq #(
    parameter int N    = 4,
    parameter int KMAX = 16,
    parameter int KW   = $clog2(KMAX + 1),
    parameter int TW   = $clog2(KMAX + 2 * N),
    parameter int RW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          op_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          array_clr,
    output logic [TW-1:0] feed_t,
    output logic [N-1:0]  lane_valid,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_row
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k_q;
    logic          err_q;
    logic [TW-1:0] feed_t_q;
    logic [RW-1:0] flush_cnt;
    logic [RW-1:0] row_q;

    logic accept;
    logic k_bad;
    logic last_feed;
    logic last_flush;
    logic last_row;
    logic row_hs;

    assign accept     = (state == S_IDLE) && start && op_ready;
    assign k_bad      = (k_len == '0) || (int'(k_len) > KMAX);
    // The skew means lane N-1 injects its last operand at step K+N-2.
    assign last_feed  = (int'(feed_t_q) == int'(k_q) + N - 2);
    assign last_flush = (int'(flush_cnt) == N - 2);
    assign last_row   = (int'(row_q) == N - 1);
    assign row_hs     = (state == S_DRAIN) && res_ready;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nxt = k_bad ? S_DONE : S_CLEAR;
            end
            S_CLEAR: state_nxt = S_FEED;
            S_FEED: begin
                if (last_feed) state_nxt = (N == 1) ? S_DRAIN : S_FLUSH;
            end
            S_FLUSH: begin
                if (last_flush) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (row_hs && last_row) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            err_q     <= 1'b0;
            feed_t_q  <= '0;
            flush_cnt <= '0;
            row_q     <= '0;
        end else begin
            if (accept) begin
                k_q   <= k_len;
                err_q <= k_bad;
            end

            if (state == S_CLEAR) begin
                feed_t_q <= '0;
            end else if (state == S_FEED && !last_feed) begin
                feed_t_q <= feed_t_q + TW'(1);
            end

            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + RW'(1);
            end else begin
                flush_cnt <= '0;
            end

            if (state != S_DRAIN) begin
                row_q <= '0;
            end else if (row_hs && !last_row) begin
                row_q <= row_q + RW'(1);
            end
        end
    end

    always_comb begin
        lane_valid = '0;
        if (state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                lane_valid[i] = (int'(feed_t_q) >= i) && (int'(feed_t_q) < i + int'(k_q));
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_DONE) && err_q;
    assign array_clr = (state == S_CLEAR);
    assign feed_t    = feed_t_q;
    assign res_valid = (state == S_DRAIN);
    assign res_row   = (state == S_DRAIN) ? row_q : '0;

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Sequencer for an N×N output-stationary systolic array of signed MAC processing elements (PEs).
- Per job it: clears the array accumulators; generates the skewed per-lane injection schedule for the west (A) and north (B) operand feeders; flushes the pipeline; drains results row by row over a valid/ready handshake.
- Sits between the job-issue logic and the operand buffers/array. Does no arithmetic on operand data.

Parameters:
- N, 4, array dimension (rows = cols = lanes), N >= 1
- KMAX, 16, maximum inner dimension K per job (sets accumulator headroom)
- KW, $clog2(KMAX+1), width of k_len
- TW, $clog2(KMAX+2*N), width of feed_t

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; accepted only in IDLE
- k_len  in  KW  inner dimension K; sampled on accept
- op_ready  in  1  operand buffers loaded; required for accept
- busy  out  1  high from accept until DONE inclusive
- done  out  1  1-cycle completion pulse
- err  out  1  1-cycle pulse, coincident with done, on rejected K
- array_clr  out  1  1-cycle accumulator clear to array (top level ORs with ~rst_n)
- feed_t  out  TW  injection step counter, valid while feeding
- lane_valid  out  N  bit i: lane i injects A[i][t-i] / B[t-i][i]; else inject zero
- res_valid  out  1  result row available
- res_ready  in  1  result consumer ready
- res_row  out  $clog2(N) or 1 if N=1  row index being drained

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters 0. Reset mid-job abandons it; no done pulse.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - Accept when start && op_ready. k_len is latched.
  - If k_len==0 or k_len>KMAX: go to DONE with err; no clear/feed.
  - Otherwise go to CLEAR.
  - start without op_ready, or start in any other state: ignored, not queued.
- CLEAR: exactly 1 cycle, array_clr=1. Then FEED with feed_t=0.
- FEED:
  - K+N-1 cycles, feed_t = 0..K+N-2, incrementing each cycle.
  - lane_valid[i] = (feed_t >= i) && (feed_t < i+K).
- FLUSH:
  - N-1 cycles; lane_valid=0 (feeders inject zeros).
  - Skipped when N==1 (FEED goes directly to DRAIN).
  - feed_t holds its last value; don't-care outside FEED.
- DRAIN:
  - res_valid=1; res_row starts at 0.
  - Row advances on res_valid && res_ready.
  - Handshake on row N-1 -> DONE.
  - res_ready low stalls indefinitely; lane_valid stays 0 throughout, so accumulators are stable.
- DONE: 1 cycle, done=1 (err=1 if rejected). Then IDLE; busy drops the following cycle.
- busy: 1 in CLEAR, FEED, FLUSH, DRAIN, DONE.
- array_clr, res_valid and lane_valid: never asserted outside CLEAR, DRAIN and FEED respectively.
- Latency, valid K, res_ready tied high, accept at cycle 0:
  - CLEAR at 1
  - FEED at 2..K+N
  - FLUSH at K+N+1..K+2N-1
  - DRAIN N cycles
  - done at cycle K+3N.
- Timing invariant: an injection at lane i, step t reaches PE(i,j) at step t+j. The last useful product lands at PE(N-1,N-1) in the final FLUSH cycle.

Test Plan:
- N=4, K=3, res_ready=1, start+op_ready at cycle 0:
  - array_clr at 1; FEED cycles 2-7 with lane_valid 0001,0011,0111,1110,1100,1000.
  - FLUSH 8-10; res_row 0..3 at 11-14; done at 15, err=0.
- Same job with 2×2 identity-like operands through a 4×4 array model: drained accumulators equal the reference matrix product. Back-to-back second job: first-job sums fully cleared.
- DRAIN with res_ready low for 5 cycles on row 2: res_row holds 2, res_valid held high, lane_valid=0, done delayed exactly 5 cycles.
- k_len=0 and k_len=17 (KMAX=16): done and err pulse at cycle 1; array_clr never asserted; busy high only for cycle 1.
- start with op_ready=0, and start asserted during FEED: both ignored, no state change, no extra done.
- rst_n low mid-FEED, then released: all outputs 0 immediately. The next start (K=1, N=4) runs a full clean sequence: done at cycle 13.
